alarm_bank: RTL and testbench

//  Parametrised multi-channel alarm engine for the digital clock: holds N_ALARMS hour/minute alarms.

---
 rtl/alarm_bank_pkg.sv | 17 +
 rtl/alarm_bank_tick_down_counter.sv | 37 +++
 rtl/alarm_bank.sv | 191 +++++++++++++++++++
 tb/tb_alarm_bank.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/alarm_bank_pkg.sv
// Shared constants, FSM encoding and BCD helper for the alarm bank.
package alarm_bank_pkg;

  localparam logic [7:0] HOUR_MAX = 8'h23;
  localparam logic [7:0] MIN_MAX  = 8'h59;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StRing = 1'b1
  } ring_state_e;

  // True when both nibbles hold a decimal digit.
  function automatic logic bcd_valid(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

endpackage

// File: rtl/alarm_bank_tick_down_counter.sv
// Loadable down-counter advanced by a 1 Hz strobe; flags the tick that brings it to zero.
module alarm_bank_tick_down_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] value_i,
  input  logic         tick_i,
  output logic         zero_o
);

  logic [W-1:0] count_q, count_d;

  // Load has priority over a coincident tick; the count parks at zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = value_i;
    end else if (tick_i && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Pulses only on the cycle whose tick takes a nonzero count to zero.
  assign zero_o = (count_q != '0) && (count_d == '0);

endmodule

// File: rtl/alarm_bank.sv
// Multi-channel hour/minute alarm engine with timed bell, stop and single-slot snooze.
module alarm_bank
  import alarm_bank_pkg::*;
#(
  parameter int unsigned N_ALARMS   = 4,
  parameter int unsigned IDXW       = 2,
  parameter int unsigned RING_SEC   = 5,
  parameter int unsigned SNOOZE_SEC = 300
) (
  input  logic            clk_50M,
  input  logic            rst,
  input  logic            tick_1hz,
  input  logic [7:0]      hour_time,
  input  logic [7:0]      minute_time,
  input  logic [7:0]      second_time,
  input  logic            wr_en,
  input  logic [IDXW-1:0] wr_idx,
  input  logic [7:0]      wr_hour,
  input  logic [7:0]      wr_minute,
  input  logic            wr_enable,
  input  logic [IDXW-1:0] rd_idx,
  output logic [7:0]      rd_hour,
  output logic [7:0]      rd_minute,
  output logic            rd_enable,
  input  logic            stop_key,
  input  logic            snooze_key,
  output logic            bell_out,
  output logic [IDXW-1:0] ring_idx,
  output logic            snooze_busy
);

  logic [7:0]          hour_q [N_ALARMS];
  logic [7:0]          min_q  [N_ALARMS];
  logic [N_ALARMS-1:0] en_q;

  ring_state_e         state_q, state_d;
  logic                bell_q;
  logic [IDXW-1:0]     ring_idx_q, ring_idx_d;
  logic [N_ALARMS-1:0] pending_q, pending_d;
  logic                snz_busy_q, snz_busy_d;
  logic [IDXW-1:0]     snz_ch_q, snz_ch_d;

  logic                wr_ok, dis_wr;
  logic [N_ALARMS-1:0] match_vec, dis_vec, snz_set, pend_all, pick_oh;
  logic                pick_valid;
  logic [IDXW-1:0]     pick_idx;
  logic                in_ring, ring_start, stop_hit, snz_hit, dis_ring, leave_ring;
  logic                ring_zero, snz_zero, ring_expire, snz_expire;

  // Accept a write only when the index exists and both fields are legal BCD time values.
  always_comb begin
    wr_ok  = wr_en && (32'(wr_idx) < N_ALARMS) &&
             bcd_valid(wr_hour) && (wr_hour <= HOUR_MAX) &&
             bcd_valid(wr_minute) && (wr_minute <= MIN_MAX);
    dis_wr = wr_ok && !wr_enable;
  end

  // Alarm register file; matches below see the pre-write contents.
  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < int'(N_ALARMS); k++) begin
        hour_q[k] <= 8'h00;
        min_q[k]  <= 8'h00;
      end
      en_q <= '0;
    end else if (wr_ok) begin
      hour_q[wr_idx] <= wr_hour;
      min_q[wr_idx]  <= wr_minute;
      en_q[wr_idx]   <= wr_enable;
    end
  end

  // Combinational read port; out-of-range indices read as zero.
  always_comb begin
    rd_hour   = 8'h00;
    rd_minute = 8'h00;
    rd_enable = 1'b0;
    if (32'(rd_idx) < N_ALARMS) begin
      rd_hour   = hour_q[rd_idx];
      rd_minute = min_q[rd_idx];
      rd_enable = en_q[rd_idx];
    end
  end

  alarm_bank_tick_down_counter #(
    .W(8)
  ) u_ring_cnt (
    .clk_i  (clk_50M),
    .rst_i  (rst),
    .load_i (ring_start),
    .value_i(8'(RING_SEC)),
    .tick_i (tick_1hz),
    .zero_o (ring_zero)
  );

  alarm_bank_tick_down_counter #(
    .W(16)
  ) u_snooze_cnt (
    .clk_i  (clk_50M),
    .rst_i  (rst),
    .load_i (snz_hit),
    .value_i(16'(SNOOZE_SEC)),
    .tick_i (tick_1hz),
    .zero_o (snz_zero)
  );

  // Per-channel match, disable and snooze-expiry vectors, then the lowest-index pick.
  always_comb begin
    snz_expire = snz_busy_q && snz_zero;
    for (int k = 0; k < int'(N_ALARMS); k++) begin
      match_vec[k] = tick_1hz && (second_time == 8'h00) && en_q[k] &&
                     (hour_q[k] == hour_time) && (min_q[k] == minute_time);
      dis_vec[k]   = dis_wr && (wr_idx == IDXW'(k));
      snz_set[k]   = snz_expire && (snz_ch_q == IDXW'(k));
    end
    // Disabling a channel beats a same-cycle match or snooze expiry on it.
    pend_all   = (pending_q | match_vec | snz_set) & ~dis_vec;
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int k = int'(N_ALARMS) - 1; k >= 0; k--) begin
      if (pend_all[k]) begin
        pick_valid = 1'b1;
        pick_idx   = IDXW'(k);
      end
    end
    for (int k = 0; k < int'(N_ALARMS); k++) begin
      pick_oh[k] = pick_valid && (pick_idx == IDXW'(k));
    end
  end

  // Next-state decode: stop beats snooze; any key or disable beats ring expiry.
  always_comb begin
    in_ring     = (state_q == StRing);
    ring_start  = !in_ring && pick_valid;
    stop_hit    = in_ring && stop_key;
    snz_hit     = in_ring && snooze_key && !stop_key;
    dis_ring    = in_ring && dis_wr && (wr_idx == ring_idx_q);
    ring_expire = in_ring && ring_zero;
    leave_ring  = stop_hit || snz_hit || dis_ring || ring_expire;

    state_d = state_q;
    if (ring_start) begin
      state_d = StRing;
    end else if (leave_ring) begin
      state_d = StIdle;
    end

    ring_idx_d = ring_start ? pick_idx : ring_idx_q;
    pending_d  = ring_start ? (pend_all & ~pick_oh) : pend_all;

    snz_busy_d = snz_busy_q;
    snz_ch_d   = snz_ch_q;
    if (snz_expire) begin
      snz_busy_d = 1'b0;
    end
    if (snz_hit) begin
      snz_busy_d = 1'b1;
      snz_ch_d   = ring_idx_q;
    end
    if (stop_hit && (snz_ch_q == ring_idx_q)) begin
      snz_busy_d = 1'b0;
    end
    if (dis_wr && (wr_idx == snz_ch_d)) begin
      snz_busy_d = 1'b0;
    end
  end

  // Ring FSM with registered outputs.
  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      bell_q     <= 1'b0;
      ring_idx_q <= '0;
      pending_q  <= '0;
      snz_busy_q <= 1'b0;
      snz_ch_q   <= '0;
    end else begin
      state_q    <= state_d;
      bell_q     <= (state_d == StRing);
      ring_idx_q <= ring_idx_d;
      pending_q  <= pending_d;
      snz_busy_q <= snz_busy_d;
      snz_ch_q   <= snz_ch_d;
    end
  end

  assign bell_out    = bell_q;
  assign ring_idx    = ring_idx_q;
  assign snooze_busy = snz_busy_q;

endmodule

// File: tb/tb_alarm_bank.sv
// Scoreboard bench for alarm_bank: expectations queued at stimulus, compared after the edge.
module tb_alarm_bank;

  localparam int unsigned IDXW = 2;

  logic            clk_50M = 1'b0;
  logic            rst = 1'b1;
  logic            tick_1hz = 1'b0;
  logic [7:0]      hour_time = 8'h00, minute_time = 8'h00, second_time = 8'h00;
  logic            wr_en = 1'b0;
  logic [IDXW-1:0] wr_idx = '0;
  logic [7:0]      wr_hour = 8'h00, wr_minute = 8'h00;
  logic            wr_enable = 1'b0;
  logic [IDXW-1:0] rd_idx = '0;
  logic [7:0]      rd_hour, rd_minute;
  logic            rd_enable;
  logic            stop_key = 1'b0, snooze_key = 1'b0;
  logic            bell_out;
  logic [IDXW-1:0] ring_idx;
  logic            snooze_busy;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    string       tag;
    int          kind;  // 0: {bell,ring_idx,busy}  1: {rd_hour,rd_minute,rd_enable}
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];

  alarm_bank #(
    .N_ALARMS  (4),
    .IDXW      (IDXW),
    .RING_SEC  (5),
    .SNOOZE_SEC(300)
  ) dut (
    .clk_50M    (clk_50M),
    .rst        (rst),
    .tick_1hz   (tick_1hz),
    .hour_time  (hour_time),
    .minute_time(minute_time),
    .second_time(second_time),
    .wr_en      (wr_en),
    .wr_idx     (wr_idx),
    .wr_hour    (wr_hour),
    .wr_minute  (wr_minute),
    .wr_enable  (wr_enable),
    .rd_idx     (rd_idx),
    .rd_hour    (rd_hour),
    .rd_minute  (rd_minute),
    .rd_enable  (rd_enable),
    .stop_key   (stop_key),
    .snooze_key (snooze_key),
    .bell_out   (bell_out),
    .ring_idx   (ring_idx),
    .snooze_busy(snooze_busy)
  );

  always #5 clk_50M = ~clk_50M;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", tag, obs, exp);
    end
  endtask

  task automatic push_out(input string tag, input logic b, input logic [IDXW-1:0] i,
                          input logic s);
    sb_q.push_back('{tag: tag, kind: 0, exp: 32'({b, i, s})});
  endtask

  task automatic pop_cmp();
    exp_t e;
    logic [31:0] obs;
    e = sb_q.pop_front();
    if (e.kind == 0) obs = 32'({bell_out, ring_idx, snooze_busy});
    else             obs = 32'({rd_hour, rd_minute, rd_enable});
    check(e.tag, obs, e.exp);
  endtask

  task automatic chk_rd(input string tag, input logic [IDXW-1:0] idx, input logic [7:0] h,
                        input logic [7:0] m, input logic en);
    sb_q.push_back('{tag: tag, kind: 1, exp: 32'({h, m, en})});
    rd_idx = idx;
    #1;
    pop_cmp();
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_50M);
    #1;
  endtask

  task automatic tick(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    hour_time = h; minute_time = m; second_time = s; tick_1hz = 1'b1;
    cyc(1);
    tick_1hz = 1'b0;
  endtask

  task automatic wr(input logic [IDXW-1:0] idx, input logic [7:0] h, input logic [7:0] m,
                    input logic en);
    wr_en = 1'b1; wr_idx = idx; wr_hour = h; wr_minute = m; wr_enable = en;
    cyc(1);
    wr_en = 1'b0;
  endtask

  task automatic keys(input logic stp, input logic snz);
    stop_key = stp; snooze_key = snz;
    cyc(1);
    stop_key = 1'b0; snooze_key = 1'b0;
  endtask

  initial begin
    cyc(3);
    push_out("reset_out", 1'b0, 2'd0, 1'b0); pop_cmp();
    chk_rd("reset_rd0", 2'd0, 8'h00, 8'h00, 1'b0);
    cyc(1);
    rst = 1'b0;
    cyc(1);

    // Single channel rings for exactly five ticks.
    wr(2'd1, 8'h07, 8'h30, 1'b1);
    chk_rd("wr_ch1", 2'd1, 8'h07, 8'h30, 1'b1);
    push_out("ch1_ring", 1'b1, 2'd1, 1'b0); tick(8'h07, 8'h30, 8'h00); pop_cmp();
    push_out("ch1_still", 1'b1, 2'd1, 1'b0);
    for (int s = 1; s < 5; s++) tick(8'h07, 8'h30, 8'(s));
    pop_cmp();
    push_out("ch1_autostop", 1'b0, 2'd1, 1'b0); tick(8'h07, 8'h30, 8'h05); pop_cmp();

    // Two channels on the same minute ring back to back, lowest first.
    wr(2'd0, 8'h06, 8'h00, 1'b1);
    wr(2'd2, 8'h06, 8'h00, 1'b1);
    push_out("dual_ch0", 1'b1, 2'd0, 1'b0); tick(8'h06, 8'h00, 8'h00); pop_cmp();
    for (int s = 1; s < 5; s++) tick(8'h06, 8'h00, 8'(s));
    push_out("ch0_end", 1'b0, 2'd0, 1'b0); tick(8'h06, 8'h00, 8'h05); pop_cmp();
    push_out("ch2_start", 1'b1, 2'd2, 1'b0); cyc(1); pop_cmp();
    for (int s = 6; s < 10; s++) tick(8'h06, 8'h00, 8'(s));
    push_out("ch2_end", 1'b0, 2'd2, 1'b0); tick(8'h06, 8'h00, 8'h10); pop_cmp();
    push_out("no_more", 1'b0, 2'd2, 1'b0); cyc(2); pop_cmp();

    // Snooze re-rings after 300 ticks.
    wr(2'd3, 8'h05, 8'h00, 1'b1);
    push_out("ch3_ring", 1'b1, 2'd3, 1'b0); tick(8'h05, 8'h00, 8'h00); pop_cmp();
    push_out("snooze", 1'b0, 2'd3, 1'b1); keys(1'b0, 1'b1); pop_cmp();
    push_out("snz_wait", 1'b0, 2'd3, 1'b1);
    repeat (299) tick(8'h05, 8'h00, 8'h01);
    pop_cmp();
    push_out("snz_ring", 1'b1, 2'd3, 1'b0); tick(8'h05, 8'h00, 8'h01); pop_cmp();
    push_out("stop", 1'b0, 2'd3, 1'b0); keys(1'b1, 1'b0); pop_cmp();

    // Both keys together: stop wins and cancels the armed snooze.
    push_out("ch3_ring2", 1'b1, 2'd3, 1'b0); tick(8'h05, 8'h00, 8'h00); pop_cmp();
    push_out("snooze2", 1'b0, 2'd3, 1'b1); keys(1'b0, 1'b1); pop_cmp();
    push_out("ring_w_snz", 1'b1, 2'd3, 1'b1); tick(8'h05, 8'h00, 8'h00); pop_cmp();
    push_out("both_keys", 1'b0, 2'd3, 1'b0); keys(1'b1, 1'b1); pop_cmp();

    // Invalid writes are dropped.
    wr(2'd0, 8'h24, 8'h00, 1'b1);
    chk_rd("bad_hour", 2'd0, 8'h06, 8'h00, 1'b1);
    wr(2'd0, 8'h06, 8'h5A, 1'b1);
    chk_rd("bad_min", 2'd0, 8'h06, 8'h00, 1'b1);
    wr(2'd0, 8'h1A, 8'h00, 1'b0);
    chk_rd("bad_nib", 2'd0, 8'h06, 8'h00, 1'b1);

    // Disabling the ringing channel stops the bell next cycle.
    push_out("ch1_ring2", 1'b1, 2'd1, 1'b0); tick(8'h07, 8'h30, 8'h00); pop_cmp();
    push_out("disable_ring", 1'b0, 2'd1, 1'b0); wr(2'd1, 8'h07, 8'h30, 1'b0); pop_cmp();
    chk_rd("ch1_dis", 2'd1, 8'h07, 8'h30, 1'b0);
    push_out("dis_hold", 1'b0, 2'd1, 1'b0);
    tick(8'h07, 8'h30, 8'h00);
    tick(8'h07, 8'h30, 8'h01);
    pop_cmp();

    // Keys in idle do nothing.
    push_out("idle_keys", 1'b0, 2'd1, 1'b0);
    keys(1'b1, 1'b0);
    keys(1'b0, 1'b1);
    pop_cmp();

    // Asynchronous reset while ringing with snooze armed.
    push_out("ch3_ring3", 1'b1, 2'd3, 1'b0); tick(8'h05, 8'h00, 8'h00); pop_cmp();
    push_out("snooze3", 1'b0, 2'd3, 1'b1); keys(1'b0, 1'b1); pop_cmp();
    push_out("ch0_ring_snz", 1'b1, 2'd0, 1'b1); tick(8'h06, 8'h00, 8'h00); pop_cmp();
    #2;
    rst = 1'b1;
    #1;
    push_out("async_rst", 1'b0, 2'd0, 1'b0); pop_cmp();
    chk_rd("rst_clr0", 2'd0, 8'h00, 8'h00, 1'b0);
    cyc(1);
    rst = 1'b0;
    push_out("post_rst", 1'b0, 2'd0, 1'b0);
    tick(8'h06, 8'h00, 8'h00);
    tick(8'h05, 8'h00, 8'h00);
    repeat (10) tick(8'h05, 8'h00, 8'h01);
    cyc(5);
    pop_cmp();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
